mdu: RTL and testbench
======================

# mdu

Iterative multiply/divide unit for the MIPS execute stage. Takes the same register-file operands the ALU receives, runs MULT/MULTU/DIV/DIVU over 33 cycles, and holds results in architectural HI/LO registers. MFHI/MFLO read `hi`/`lo` through the execute-stage result mux downstream of the ALU. A start/busy handshake lets the pipeline controller stall on dependent MFHI/MFLO.

## Interface
- No parameters. Width is fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `srca`  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO source.
- `srcb`  in  32  rt operand: divisor or multiplier.
- `mdop`  in  3  operation code:
  - 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - Any other code is a no-op.
- `start`  in  1  request; sampled only when `busy`=0.
- `busy`  out  1  high while an iterative operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated by MULT/MULTU/DIV/DIVU.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, `start`=1, mdop MULT/MULTU:
  - Latch operand magnitudes (signed op) or raw values (unsigned).
  - Record result sign = srca[31]^srcb[31] (signed only).
  - Clear 64-bit product, set counter to 0, go to MUL.
- IDLE, `start`=1, mdop DIV/DIVU:
  - Latch magnitudes.
  - Record quotient sign = srca[31]^srcb[31] and remainder sign = srca[31] (signed only).
  - Go to DIV.
- IDLE, `start`=1, mdop MTHI/MTLO:
  - `hi` (or `lo`) <= srca at that edge.
  - Stay IDLE; `busy` and `done` are not asserted.
- IDLE, `start`=1, other mdop: ignored.
- MUL: one shift-add step per cycle for 32 cycles (counter 0..31), then go to FIX.
- DIV: one restoring shift-subtract step per cycle for 32 cycles, then go to FIX.
- FIX: takes one cycle.
  - Apply two's-complement negation for signed ops.
  - MUL: write {hi,lo} <= 64-bit product.
  - DIV: write lo <= quotient, hi <= remainder.
  - Go to IDLE.
- Arithmetic rules:
  - Signed divide truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 2^31.
- Divide by zero, DIV or DIVU: same latency; lo=0xFFFFFFFF, hi=srca as latched.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- `start` while `busy`=1 is ignored: no queueing, no error.
- `hi`/`lo` keep their old values until the FIX edge.
- Operand changes after the accepting edge have no effect.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately: HI/LO return to 0 and no `done` pulse is produced.
- Accepting edge E0 (IDLE, start=1, valid iterative mdop):
  - `busy`=1 from after E0 through E33: 33 cycles.
  - Iteration edges E1..E32; FIX edge E33.
  - New `hi`/`lo` visible after E33.
  - `done`=1 for exactly the cycle after E33; `busy`=0 in that same cycle.
- A new `start` is accepted at E34 at the earliest. Back-to-back operations therefore run with no dead cycle beyond the `done` cycle.
- MTHI/MTLO: result visible the cycle after the accepting edge. A back-to-back MTHI then MTLO takes 2 consecutive edges.
- `busy` and `done` are registered outputs, not combinational from `start`.

## Test plan
- Reset, then MULT srca=0xFFFFFFFF srcb=0x00000002:
  - `busy` high 33 cycles, then `done` pulse.
  - hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands: hi=0x00000001, lo=0xFFFFFFFE.
- DIV srca=0xFFFFFFF9 (-7) srcb=0x00000002: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 7/2: lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 5/0: lo=0xFFFFFFFF, hi=5, latency unchanged.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive edges:
  - Each visible next cycle.
  - `busy`/`done` stay 0.
- Start MULT 3*4. Pulse `start` with DIVU at cycle 10; assert async `reset` at cycle 20 for one cycle, then restart MULT 3*4:
  - The DIVU is ignored.
  - The reset clears hi/lo/busy immediately with no `done` pulse.
  - The restarted MULT completes 33 cycles later with lo=12, hi=0.

Source files
------------

// File: rtl/mdu_if.sv
// Handshake and operand bundle between the execute stage and the multiply/divide unit.
interface mdu_if;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [2:0]  mdop;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output srca, srcb, mdop, start,
    input  busy, done, hi, lo
  );

  modport slave (
    input  srca, srcb, mdop, start,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mdu (
  input logic   clk,
  input logic   reset,
  mdu_if.slave  bus
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] op_q;
  logic [63:0] acc_q;
  logic        sign_q;
  logic        rsign_q;
  logic        is_div_q;
  logic        dz_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        signed_op_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_rem_s;
  logic [32:0] div_diff_s;
  logic [63:0] mul_step_d;
  logic [63:0] div_step_d;
  logic [63:0] prod_neg_s;
  logic [31:0] quo_neg_s;
  logic [31:0] rem_neg_s;
  logic [31:0] fix_hi_d;
  logic [31:0] fix_lo_d;

  // Operand magnitudes and one datapath step for each iterative op.
  always_comb begin
    signed_op_s = (bus.mdop == OP_MULT) || (bus.mdop == OP_DIV);
    a_mag_s     = (signed_op_s && bus.srca[31]) ? (32'd0 - bus.srca) : bus.srca;
    b_mag_s     = (signed_op_s && bus.srcb[31]) ? (32'd0 - bus.srcb) : bus.srcb;

    // Multiplier sits in acc low half and is consumed LSB-first as the product shifts in.
    mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, op_q} : 33'd0);
    mul_step_d = {mul_sum_s, acc_q[31:1]};

    div_rem_s  = {acc_q[63:32], acc_q[31]};
    div_diff_s = div_rem_s - {1'b0, op_q};
    if (div_rem_s >= {1'b0, op_q}) begin
      div_step_d = {div_diff_s[31:0], acc_q[30:0], 1'b1};
    end else begin
      div_step_d = {div_rem_s[31:0], acc_q[30:0], 1'b0};
    end
  end

  // Sign correction applied on the FIX edge; a zero divisor keeps the all-ones quotient.
  always_comb begin
    prod_neg_s = 64'd0 - acc_q;
    quo_neg_s  = 32'd0 - acc_q[31:0];
    rem_neg_s  = 32'd0 - acc_q[63:32];
    if (is_div_q) begin
      fix_lo_d = (sign_q && !dz_q) ? quo_neg_s : acc_q[31:0];
      fix_hi_d = rsign_q ? rem_neg_s : acc_q[63:32];
    end else begin
      fix_lo_d = sign_q ? prod_neg_s[31:0]  : acc_q[31:0];
      fix_hi_d = sign_q ? prod_neg_s[63:32] : acc_q[63:32];
    end
  end

  // Control FSM with registered HI/LO, busy and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 32'd0;
      acc_q    <= 64'd0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            case (bus.mdop)
              OP_MULT, OP_MULTU: begin
                op_q     <= a_mag_s;
                acc_q    <= {32'd0, b_mag_s};
                sign_q   <= signed_op_s && (bus.srca[31] ^ bus.srcb[31]);
                rsign_q  <= 1'b0;
                is_div_q <= 1'b0;
                dz_q     <= 1'b0;
                cnt_q    <= 5'd0;
                busy_q   <= 1'b1;
                state_q  <= S_MUL;
              end
              OP_DIV, OP_DIVU: begin
                op_q     <= b_mag_s;
                acc_q    <= {32'd0, a_mag_s};
                sign_q   <= signed_op_s && (bus.srca[31] ^ bus.srcb[31]);
                rsign_q  <= signed_op_s && bus.srca[31];
                is_div_q <= 1'b1;
                dz_q     <= (bus.srcb == 32'd0);
                cnt_q    <= 5'd0;
                busy_q   <= 1'b1;
                state_q  <= S_DIV;
              end
              OP_MTHI: hi_q <= bus.srca;
              OP_MTLO: lo_q <= bus.srca;
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_MUL: begin
          acc_q <= mul_step_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end
        end
        S_DIV: begin
          acc_q <= div_step_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          cnt_q   <= 5'd0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed plus small random bench for mdu; expected HI/LO are queued at issue
// time and popped when the done pulse arrives.
module tb_mdu;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_pass = 0;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  mdu_if bus ();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    p = 64'd0;
    q = 32'd0;
    r = 32'd0;
    case (op)
      OP_MULT:  p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        p = {r, q};
      end
      OP_DIVU: p = {a % b, a / b};
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Issue one iterative op, check latency, hold-until-FIX, done pulse and result.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    int   n;
    e.tag = tag;
    e.hi  = ehi;
    e.lo  = elo;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdop  = op;
    bus.srca  = a;
    bus.srcb  = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srca  = ~a;
    bus.srcb  = $urandom;
    chk({tag, "_hi_hold"}, bus.hi, cur_hi);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (n == 16) begin
        chk({tag, "_lo_hold"}, bus.lo, cur_lo);
        chk({tag, "_no_early_done"}, {31'd0, bus.done}, 32'd0);
      end
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, n, 32'd33);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    e = sb_q.pop_front();
    chk({e.tag, "_hi"}, bus.hi, e.hi);
    chk({e.tag, "_lo"}, bus.lo, e.lo);
    cur_hi = e.hi;
    cur_lo = e.lo;
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mdop  = 3'b000;
    bus.srca  = 32'd0;
    bus.srcb  = 32'd0;
    cur_hi    = 32'd0;
    cur_lo    = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b0;

    run_op("mult",   OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu",  OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg", OP_DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",   OP_DIVU,  32'd7,        32'd2,        32'd1,        32'd3);
    run_op("div_ovf", OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_z", OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
    run_op("div_z",  OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);

    for (int i = 0; i < 4; i++) begin
      ra  = $urandom;
      rb  = $urandom | 32'd1;
      rop = 3'(i + 1);
      m   = model(rop, ra, rb);
      run_op($sformatf("rand%0d", i), rop, ra, rb, m[63:32], m[31:0]);
    end

    // MTHI then MTLO on consecutive edges.
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdop  = OP_MTHI;
    bus.srca  = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_busy", {31'd0, bus.busy}, 32'd0);
    bus.mdop = OP_MTLO;
    bus.srca = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
    chk("mtlo_hi_keep", bus.hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    chk("mtlo_done", {31'd0, bus.done}, 32'd0);

    // MULT, ignored DIVU while busy, then async reset mid-operation.
    bus.start = 1'b1;
    bus.mdop  = OP_MULT;
    bus.srca  = 32'd3;
    bus.srcb  = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1;
    bus.mdop  = OP_DIVU;
    bus.srca  = 32'd7;
    bus.srcb  = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_busy", {31'd0, bus.busy}, 32'd1);
    chk("ign_hi_keep", bus.hi, 32'h12345678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_done", {31'd0, bus.done}, 32'd0);
    run_op("restart", OP_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
